// File: rtl/tx_buf_pkg.sv
// tx_buf_pkg: shared sizing constants for the USB transmit data buffer
package tx_buf_pkg;
  localparam int TX_BUF_DEPTH = 64;
  localparam int TX_BUF_PTR_W = 6;
endpackage

// File: rtl/tx_buf_ram.sv
// tx_buf_ram: DEPTH x 8 byte storage, synchronous write, asynchronous read
module tx_buf_ram
  import tx_buf_pkg::*;
#(
  parameter int DEPTH = TX_BUF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  // byte write on the rising edge; contents are not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/tx_data_buffer.sv
// tx_data_buffer: show-ahead circular byte FIFO feeding the USB transmitter; TX_BUF_OVERFLOW_ERR_EN adds a sticky buffer_error output
module tx_data_buffer
  import tx_buf_pkg::*;
#(
  parameter int DEPTH = TX_BUF_DEPTH
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       store_tx_data,
  input  logic [7:0] tx_data,
  input  logic       get_tx_packet,
  input  logic       clear,
  output logic [7:0] tx_packet_data,
  output logic [6:0] tx_packet_data_size,
  output logic       buffer_full,
  output logic       buffer_empty
`ifdef TX_BUF_OVERFLOW_ERR_EN
  ,
  output logic       buffer_error
`endif
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [7:0]    rd_data;
  logic          do_wr, do_rd;
  assign buffer_full         = cnt_q == (PW+1)'(DEPTH);
  assign buffer_empty        = cnt_q == '0;
  assign tx_packet_data_size = 7'(cnt_q);
  assign tx_packet_data      = buffer_empty ? 8'h00 : rd_data;
  assign do_wr = store_tx_data & ~buffer_full & ~clear;
  assign do_rd = get_tx_packet & ~buffer_empty & ~clear;
  tx_buf_ram #(.DEPTH(DEPTH), .AW(PW)) u_ram (
    .clk   (clk),
    .we    (do_wr),
    .waddr (wp_q),
    .wdata (tx_data),
    .raddr (rp_q),
    .rdata (rd_data)
  );
  // pointers wrap naturally at DEPTH; clear flushes, simultaneous push/pop keeps occupancy
  always_comb begin
    wp_d  = clear ? '0 : wp_q + PW'(do_wr);
    rp_d  = clear ? '0 : rp_q + PW'(do_rd);
    cnt_d = clear ? '0 : cnt_q + (PW+1)'(do_wr) - (PW+1)'(do_rd);
  end
  // pointer and occupancy registers, asynchronously discarded on reset
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef TX_BUF_OVERFLOW_ERR_EN
  logic err_q, err_d;
  assign err_d = ~clear & (err_q | (store_tx_data & buffer_full) | (get_tx_packet & buffer_empty));
  // sticky flag for a refused write or pop, released only by clear or reset
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign buffer_error = err_q;
`endif
endmodule

// File: doc/tx_data_buffer.md
TX_DATA_BUFFER -- requirements
Module: tx_data_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 64: byte capacity; power of two, 2..64.
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port store_tx_data, input, 1, write strobe from the host side.
REQ-005 SHALL have port tx_data, input, 8, byte to write.
REQ-006 SHALL have port get_tx_packet, input, 1, pop strobe from the USB transmitter.
REQ-007 SHALL have port clear, input, 1, synchronous flush.
REQ-008 SHALL have port tx_packet_data, output, 8, head byte (show-ahead).
REQ-009 SHALL have port tx_packet_data_size, output, 7, current occupancy 0..DEPTH.
REQ-010 SHALL have port buffer_full, output, 1, occupancy equals DEPTH.
REQ-011 SHALL have port buffer_empty, output, 1, occupancy equals 0.

Function
REQ-012 SHALL store bytes in circular storage with write and read pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-013 SHALL write tx_data at the write pointer, advance it, and add 1 to occupancy on a clk edge with store_tx_data=1 and buffer_full=0.
REQ-014 SHALL advance the read pointer and subtract 1 from occupancy on a clk edge with get_tx_packet=1 and buffer_empty=0.
REQ-015 SHALL present the byte at the read pointer on tx_packet_data combinationally from registered state, so the pop of byte N makes byte N+1 visible the next cycle.
REQ-016 SHALL drive tx_packet_data to 8'h00 while buffer_empty=1.
REQ-017 SHALL perform both operations and leave occupancy unchanged when store and get coincide with 0<occupancy<DEPTH.
REQ-018 SHALL accept only the write when store and get coincide while empty; the written byte appears on tx_packet_data the next cycle.
REQ-019 SHALL accept only the pop when store and get coincide while full.
REQ-020 SHALL ignore writes when full and pops when empty, with storage, pointers and occupancy unchanged.
REQ-021 SHALL zero both pointers and occupancy on clear=1 and take no other action in that cycle; clear has priority over store and get.
REQ-022 SHALL derive buffer_full, buffer_empty and tx_packet_data_size from a registered occupancy counter of log2(DEPTH)+1 bits, zero-extended to 7 bits.

Reset
REQ-023 SHALL, while n_rst=0 and regardless of clk: pointers=0, occupancy=0, tx_packet_data_size=0, buffer_empty=1, buffer_full=0, tx_packet_data=8'h00.
REQ-024 SHALL discard all buffered bytes on reset mid-packet; storage contents need not reset.

Configuration
REQ-025 SHALL support macro TX_BUF_OVERFLOW_ERR_EN.
REQ-026 SHALL, when TX_BUF_OVERFLOW_ERR_EN is defined, add output buffer_error (1 bit), set the cycle after a refused write (REQ-020) or refused pop; sticky until clear or reset.
REQ-027 SHALL, when TX_BUF_OVERFLOW_ERR_EN is undefined, omit buffer_error with all other behaviour identical.

Structure
REQ-028 SHALL place the default-depth constant TX_BUF_DEPTH=64 and TX_BUF_PTR_W=6 in shared package tx_buf_pkg.
REQ-029 SHALL implement storage as sub-module tx_buf_ram (synchronous write, asynchronous read, DEPTH x 8); pointer and occupancy logic stays in tx_data_buffer.

Verification
REQ-030 SHALL check: reset, then write 8'hA5, 8'h3C -> size=2, tx_packet_data=8'hA5; one pop -> size=1, tx_packet_data=8'h3C.
REQ-031 SHALL check: 64 writes of 0..63 -> buffer_full=1, size=64; 65th write of 8'hFF ignored, with buffer_error=1 when the macro is defined; 64 pops return 0..63 in order.
REQ-032 SHALL check: at size=10, 20 cycles of simultaneous store and get -> size stays 10 and FIFO order is preserved across pointer wrap.
REQ-033 SHALL check: empty buffer, simultaneous store 8'h77 and get -> size=1, tx_packet_data=8'h77 the next cycle.
REQ-034 SHALL check: size=5 and clear asserted together with store and get -> size=0, buffer_empty=1, tx_packet_data=8'h00.
REQ-035 SHALL check: n_rst asserted mid-clock-cycle at size=30 -> outputs reach reset values immediately, with no clk edge required.
